// File: rtl/ps2_move_decoder.sv
`timescale 1ns/1ps
// ps2_move_decoder: PS/2 receiver and scancode decoder producing one-cycle move/enter pulses.
module ps2_move_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       enterEn,
    output logic       moveUpEn,
    output logic       moveDownEn,
    output logic       moveLeftEn,
    output logic       moveRightEn,
    output logic       frame_err,
    output logic [7:0] last_code
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t        state;
    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev, fall, dat;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          byte_valid;
    logic          ext, brk, hit;
    logic [2:0]    key;
    logic [4:0]    held, en;
    assign fall = clk_prev & ~clk_sync[1];
    assign dat  = dat_sync[1];
    assign {moveRightEn, moveLeftEn, moveDownEn, moveUpEn, enterEn} = en;
    // Preset to idle-high so reset release never looks like a falling edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            par        <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            last_code  <= 8'd0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            tcnt       <= (fall || state == IDLE) ? '0 : tcnt + 1'b1;
            if (fall) begin
                case (state)
                    IDLE: if (!dat) begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                    end
                    DATA: begin
                        shift   <= {dat, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if ((^shift ^ par) && dat) begin
                            byte_valid <= 1'b1;
                            last_code  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end
    // Key index: 0 enter, 1 up, 2 down, 3 left, 4 right
    always_comb begin
        hit = 1'b1;
        key = 3'd0;
        if (last_code == 8'h5A) key = 3'd0;
        else if (ext ? last_code == 8'h75 : last_code == 8'h1D) key = 3'd1;
        else if (ext ? last_code == 8'h72 : last_code == 8'h1B) key = 3'd2;
        else if (ext ? last_code == 8'h6B : last_code == 8'h1C) key = 3'd3;
        else if (ext ? last_code == 8'h74 : last_code == 8'h23) key = 3'd4;
        else hit = 1'b0;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            held <= 5'd0;
            en   <= 5'd0;
        end else begin
            en <= 5'd0;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_valid) begin
                if (last_code == 8'hE0) ext <= 1'b1;
                else if (last_code == 8'hF0) brk <= 1'b1;
                else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (hit) begin
                        held[key] <= !brk;
                        if (!brk && !held[key]) en[key] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/ps2_move_decoder.md
Name: ps2_move_decoder

Overview:
- Receives PS/2 keyboard frames and converts scancodes into the one-cycle move and enter enables consumed by the reversi datapath: `moveUpEn`, `moveDownEn`, `moveLeftEn`, `moveRightEn` and `enterEn`.
- Sits between the board's PS/2 pins and the datapath/control pair.
- Owns pin synchronisation, frame checking, timeout recovery, the extended/break prefixes and typematic suppression, so the datapath sees exactly one pulse per physical key press.

Parameters:
- TIMEOUT_CYCLES, 50000, clk cycles with no PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_dat  in  1  raw PS/2 data pin, asynchronous
- enterEn  out  1  one-cycle pulse: enter pressed
- moveUpEn  out  1  one-cycle pulse: up pressed
- moveDownEn  out  1  one-cycle pulse: down pressed
- moveLeftEn  out  1  one-cycle pulse: left pressed
- moveRightEn  out  1  one-cycle pulse: right pressed
- frame_err  out  1  one-cycle pulse on parity, stop or timeout error
- last_code  out  8  most recent correctly received byte

Behaviour:
- Reset (async, resetn=0):
  - all enables, frame_err and last_code = 0.
  - Synchroniser flops preset to 1, so there is no false edge on reset release.
  - Receiver goes to IDLE; ext, brk and held[4:0] are cleared.
- Synchronisation and edge detect:
  - 2-flop synchroniser on each pin.
  - A falling edge is: synced clk previous=1 and current=0.
  - All sampling of the data pin happens only on falling edges.
- Receiver FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: an edge with dat=0 goes to DATA with bit count 0. An edge with dat=1 is ignored.
  - DATA: shifts 8 bits LSB first, then goes to PARITY.
  - PARITY: samples the parity bit.
  - STOP: on the edge, the frame is valid iff the count of ones in data+parity is odd AND stop=1.
    - Valid frame: byte_valid is registered high for 1 cycle and last_code is updated in the same cycle.
    - Invalid frame: frame_err pulses for 1 cycle, the byte is discarded, and ext and brk are cleared.
  - Always returns to IDLE.
- Timeout:
  - The counter clears on every falling edge and in IDLE.
  - In any non-IDLE state, when it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_err, clear ext and brk.
- Decoder, acting on a byte_valid cycle:
  - E0: set ext.
  - F0: set brk.
  - Any other byte: resolve the key from (ext, code), then clear ext and brk.
- Key map (any unlisted combination is ignored, apart from clearing ext and brk):
  - up: E0 75 or 1D (W)
  - down: E0 72 or 1B (S)
  - left: E0 6B or 1C (A)
  - right: E0 74 or 23 (D)
  - enter: 5A or E0 5A
- Press and release handling:
  - Make with held[k]=0: set held[k] and pulse enable k.
  - Make with held[k]=1: typematic repeat, no pulse.
  - Break (brk=1): clear held[k], no pulse. A break for a key not held is harmless.
- Latency: the enable rises exactly 2 clk cycles after the cycle in which the stop-bit falling edge is detected, and stays high exactly 1 cycle.
- Exclusivity: at most one enable is high in any cycle.
  - Follows from one byte per frame and ≥11 PS/2 edges between bytes.
- Error during prefix: a bad frame after E0 clears ext, so a following 75 is treated as non-extended and is unmapped.
- Mid-frame reset: the partial frame is lost and no pulse is emitted. The next frame must start with a fresh start bit.

Test Plan:
- Frames E0, 75 (odd parity, ~10 kHz PS/2 clk) -> moveUpEn high exactly 1 cycle, 2 cycles after the 75 stop edge; other enables 0; last_code=0x75; frame_err never high.
- 5A, 5A, 5A, F0 5A, 5A -> enterEn pulses exactly twice: after the first 5A and after the final 5A.
- 0x23 sent with wrong parity -> frame_err 1-cycle pulse, no moveRightEn, last_code unchanged; then a valid 23 -> moveRightEn pulse.
- Start bit + 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse, receiver IDLE; then a full valid 1C -> moveLeftEn pulse.
- Unmapped 29, then E0 F0 75 with no prior press, then E0 72 -> only moveDownEn pulses, once.
- E0 received, resetn pulsed low mid-way through the next frame -> all outputs 0 immediately; then a lone valid 75 -> no enable (ext was cleared); last_code=0x75.
